// File: rtl/fpu_ss_mem_buffer.sv
// Metadata FIFO for FPU-subsystem loads/stores offloaded over the memory interface.
// Each entry is {we, rd[4:0]}. The head is read straight from storage, so there is no fall-through path.
module fpu_ss_mem_buffer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 6
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       push_valid_i,
    output logic                       push_ready_o,
    input  logic [DATA_W-1:0]          push_i,
    output logic                       pop_valid_o,
    input  logic                       pop_ready_i,
    output logic [DATA_W-1:0]          pop_o,
    output logic [$clog2(DEPTH+1)-1:0] usage_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       overflow_o,
    output logic                       underflow_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int USE_W = $clog2(DEPTH+1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH-1);
    localparam logic [USE_W-1:0] FULL_CNT = USE_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [USE_W-1:0]  usage;
    logic              push_fire, pop_fire;

    assign usage_o      = usage;
    assign full_o       = (usage == FULL_CNT);
    assign empty_o      = (usage == '0);
    assign push_ready_o = ~full_o;
    assign pop_valid_o  = ~empty_o;
    assign push_fire    = push_valid_i & push_ready_o;
    assign pop_fire     = pop_valid_o & pop_ready_i;
    assign pop_o        = empty_o ? '0 : mem[rd_ptr];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            usage       <= '0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            // Error flags are sticky across flush; only reset clears them.
            if (push_valid_i & full_o) overflow_o  <= 1'b1;
            if (pop_ready_i & empty_o) underflow_o <= 1'b1;
            if (flush_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                usage  <= '0;
            end else begin
                if (push_fire) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
                if (pop_fire)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
                case ({push_fire, pop_fire})
                    2'b10:   usage <= usage + 1'b1;
                    2'b01:   usage <= usage - 1'b1;
                    default: usage <= usage;
                endcase
            end
        end
    end

    // Storage carries no reset; contents are only observable through a valid head.
    always_ff @(posedge clk_i) begin
        if (push_fire && !flush_i) mem[wr_ptr] <= push_i;
    end

endmodule
